// File: rtl/clock_divider_pkg.sv
// Shared configuration layout and default constants for the clock divider bank.
package clock_divider_pkg;

    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_N      = 8;
    localparam int unsigned DEF_PERIOD = 1;
    localparam int unsigned DEF_HIGH   = 1;

    // Fields are sized for the widest supported N; narrower channels zero-extend.
    localparam int unsigned MAX_N = 32;

    typedef struct packed {
        logic [MAX_N-1:0] period;
        logic [MAX_N-1:0] high;
    } chan_cfg_t;

endpackage

// File: rtl/clock_divider_chan.sv
// One divider channel: period counter, active/shadow config, registered clk_out and tick.
module clock_divider_chan
    import clock_divider_pkg::*;
#(
    parameter int unsigned N          = DEF_N,
    parameter int unsigned DEF_PERIOD = clock_divider_pkg::DEF_PERIOD,
    parameter int unsigned DEF_HIGH   = clock_divider_pkg::DEF_HIGH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      sync,
    input  logic      we,
    input  chan_cfg_t cfg,
    output logic      clk_out,
    output logic      tick,
    output logic      cfg_pending
);

    localparam chan_cfg_t RST_CFG = '{period: MAX_N'(DEF_PERIOD), high: MAX_N'(DEF_HIGH)};

    logic [N-1:0] cnt, cnt_nx;
    chan_cfg_t    act, act_nx;
    chan_cfg_t    pend, pend_nx;
    logic         pend_valid, pend_valid_nx;
    logic         run_q;
    logic         wrap;

    always_comb begin
        cnt_nx        = cnt;
        act_nx        = act;
        pend_nx       = pend;
        pend_valid_nx = pend_valid;
        // run_q gates the wrap so the first enabled cycle is a forced period start
        wrap          = run_q && (cnt == N'(act.period));

        if (en) begin
            if (!run_q || sync || wrap) begin
                cnt_nx = '0;
            end else begin
                cnt_nx = cnt + N'(1);
            end
            if ((wrap || sync) && pend_valid) begin
                act_nx        = pend;
                pend_valid_nx = 1'b0;
            end
            // Applied after the boundary copy so a write landing on a wrap waits a full period
            if (we) begin
                pend_nx       = cfg;
                pend_valid_nx = 1'b1;
            end
        end else begin
            cnt_nx = '0;
            if (we) begin
                act_nx        = cfg;
                pend_valid_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            act        <= RST_CFG;
            pend       <= '0;
            pend_valid <= 1'b0;
            run_q      <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            cnt        <= cnt_nx;
            act        <= act_nx;
            pend       <= pend_nx;
            pend_valid <= pend_valid_nx;
            run_q      <= en;
            clk_out    <= en && (cnt_nx < N'(act_nx.high));
            tick       <= en && (cnt_nx == '0);
        end
    end

    assign cfg_pending = pend_valid;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent programmable clock dividers with boundary-aligned reconfiguration.
// Optional: define CLOCK_DIVIDER_BANK_SYNC_EN to add the sync port for bank-wide phase alignment.
module clock_divider_bank
    import clock_divider_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned N          = DEF_N,
    parameter int unsigned DEF_PERIOD = clock_divider_pkg::DEF_PERIOD,
    parameter int unsigned DEF_HIGH   = clock_divider_pkg::DEF_HIGH
) (
    input  logic                                             clk,
    input  logic                                             rst,
`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
    input  logic                                             sync,
`endif
    input  logic [NUM_CH-1:0]                                en,
    input  logic                                             cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]   cfg_ch,
    input  logic [N-1:0]                                     cfg_period,
    input  logic [N-1:0]                                     cfg_high,
    output logic [NUM_CH-1:0]                                clk_out,
    output logic [NUM_CH-1:0]                                tick,
    output logic [NUM_CH-1:0]                                cfg_pending
);

    chan_cfg_t wcfg;
    logic      sync_w;

    assign wcfg = '{period: MAX_N'(cfg_period), high: MAX_N'(cfg_high)};

`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range indices never match any channel, so such writes vanish
        logic we_ch;
        assign we_ch = cfg_we && (32'(cfg_ch) == i);

        clock_divider_chan #(
            .N          (N),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .en          (en[i]),
            .sync        (sync_w),
            .we          (we_ch),
            .cfg         (wcfg),
            .clk_out     (clk_out[i]),
            .tick        (tick[i]),
            .cfg_pending (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank; define CLOCK_DIVIDER_BANK_SYNC_EN to also cover sync.
module tb_clock_divider_bank;

    localparam int NCH = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           sync = 1'b0;
    logic [NCH-1:0] en = '0;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [7:0]     cfg_period = '0;
    logic [7:0]     cfg_high = '0;
    logic [NCH-1:0] clk_out, tick, cfg_pending;

    int tests = 0;
    int fails = 0;

    // Reference model: each channel tracks its position within the current period
    int       pos [NCH];
    int       per [NCH];
    int       hi  [NCH];
    int       pper[NCH];
    int       phi [NCH];
    bit       pend[NCH];
    bit       run [NCH];
    logic [NCH-1:0] m_clk, m_tick, m_pend;

    always #5 clk = ~clk;

    clock_divider_bank #(
        .NUM_CH     (NCH),
        .N          (8),
        .DEF_PERIOD (1),
        .DEF_HIGH   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
        .sync        (sync),
`endif
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_pending (cfg_pending)
    );

    task automatic cycle();
        bit s;
`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
        s = sync;
`else
        s = 1'b0;
`endif
        @(posedge clk);
        for (int c = 0; c < NCH; c++) begin
            bit wr;
            bit at_end;
            wr = cfg_we && (int'(cfg_ch) == c);
            if (rst) begin
                pos[c] = 0; per[c] = 1; hi[c] = 1; pend[c] = 0; run[c] = 0;
                m_clk[c] = 0; m_tick[c] = 0;
            end else if (!en[c]) begin
                pos[c] = 0; run[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
                if (wr) begin
                    per[c] = cfg_period; hi[c] = cfg_high; pend[c] = 0;
                end
            end else begin
                at_end = run[c] && (pos[c] == per[c]);
                if (!run[c] || s || at_end) pos[c] = 0;
                else pos[c] = pos[c] + 1;
                if ((at_end || s) && pend[c]) begin
                    per[c] = pper[c]; hi[c] = phi[c]; pend[c] = 0;
                end
                if (wr) begin
                    pper[c] = cfg_period; phi[c] = cfg_high; pend[c] = 1;
                end
                run[c] = 1;
                m_clk[c]  = (pos[c] < hi[c]);
                m_tick[c] = (pos[c] == 0);
            end
            m_pend[c] = pend[c];
        end
        #1;
    endtask

    task automatic write(input int ch, input int p, input int h);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = 8'(p); cfg_high = 8'(h);
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = '0; cfg_we = 1'b0; sync = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (clk_out !== 3'b000 || tick !== 3'b000 || cfg_pending !== 3'b000) begin
            fails++;
            $display("FAIL reset: clk_out=%b tick=%b pend=%b, required all 000", clk_out, tick, cfg_pending);
        end
    endtask

    task automatic test_basic();
        do_reset();
        write(0, 3, 2);
        en = 3'b001;
        for (int k = 0; k < 12; k++) begin
            cycle();
            tests++;
            if (clk_out[0] !== ((k % 4) < 2) || tick[0] !== ((k % 4) == 0) || clk_out[2:1] !== 2'b00) begin
                fails++;
                $display("FAIL basic k=%0d: clk_out=%b tick=%b, required clk_out[0]=%0d tick[0]=%0d",
                         k, clk_out, tick, ((k % 4) < 2), ((k % 4) == 0));
            end
        end
    endtask

    task automatic test_pending();
        do_reset();
        write(1, 3, 2);
        en = 3'b010;
        cycle(); cycle();
        write(1, 5, 1);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (cfg_pending[1] !== 1'b1 || clk_out[1] !== 1'b0) begin
                fails++;
                $display("FAIL pending_hold k=%0d: pend=%b clk_out=%b, required pend[1]=1 clk_out[1]=0",
                         k, cfg_pending, clk_out);
            end
            cycle();
        end
        for (int k = 0; k < 12; k++) begin
            tests++;
            if (clk_out[1] !== ((k % 6) == 0) || tick[1] !== ((k % 6) == 0) || cfg_pending[1] !== 1'b0) begin
                fails++;
                $display("FAIL pending_apply k=%0d: clk_out=%b tick=%b pend=%b, required clk/tick[1]=%0d pend=0",
                         k, clk_out, tick, cfg_pending, ((k % 6) == 0));
            end
            cycle();
        end
    endtask

    task automatic test_extremes();
        do_reset();
        write(0, 4, 0);
        write(1, 4, 9);
        write(2, 0, 1);
        en = 3'b111;
        for (int k = 0; k < 10; k++) begin
            cycle();
            tests++;
            if (clk_out[0] !== 1'b0 || clk_out[1] !== 1'b1 || tick[2] !== 1'b1 || clk_out[2] !== 1'b1) begin
                fails++;
                $display("FAIL extremes k=%0d: clk_out=%b tick=%b, required clk_out=11x0 pattern 110 and tick[2]=1",
                         k, clk_out, tick);
            end
        end
    endtask

    task automatic test_ignore_and_wrap_write();
        int guard;
        do_reset();
        write(0, 3, 2);
        en = 3'b011;
        cycle();
        write(3, 7, 7);
        tests++;
        if (cfg_pending !== 3'b000 || clk_out !== m_clk || tick !== m_tick) begin
            fails++;
            $display("FAIL ignored_write: clk_out=%b tick=%b pend=%b, required %b %b 000",
                     clk_out, tick, cfg_pending, m_clk, m_tick);
        end
        guard = 0;
        while (pos[0] != per[0] && guard < 10) begin
            cycle();
            guard++;
        end
        tests++;
        if (guard >= 10) begin
            fails++;
            $display("FAIL wrap_search: no period end found, got pos=%0d required %0d", pos[0], per[0]);
        end
        write(0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (cfg_pending[0] !== 1'b1 || clk_out[0] !== ((k % 4) < 2) || tick[0] !== (k == 0)) begin
                fails++;
                $display("FAIL wrap_write k=%0d: clk_out=%b tick=%b pend=%b, required old period and pend[0]=1",
                         k, clk_out, tick, cfg_pending);
            end
            cycle();
        end
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (clk_out !== m_clk || tick !== m_tick || cfg_pending !== m_pend || clk_out[0] !== ((k % 2) == 0)) begin
                fails++;
                $display("FAIL wrap_applied k=%0d: clk_out=%b tick=%b pend=%b, required %b %b %b",
                         k, clk_out, tick, cfg_pending, m_clk, m_tick, m_pend);
            end
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        write(0, 5, 3);
        en = 3'b001;
        cycle(); cycle();
        write(0, 7, 7);
        rst = 1'b1;
        cycle();
        tests++;
        if (clk_out !== 3'b000 || tick !== 3'b000 || cfg_pending !== 3'b000) begin
            fails++;
            $display("FAIL reset_mid: clk_out=%b tick=%b pend=%b, required 000 000 000", clk_out, tick, cfg_pending);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            tests++;
            if (clk_out[0] !== ((k % 2) == 0) || tick[0] !== ((k % 2) == 0) || cfg_pending[0] !== 1'b0) begin
                fails++;
                $display("FAIL reset_defaults k=%0d: clk_out=%b tick=%b pend=%b, required clk/tick[0]=%0d",
                         k, clk_out, tick, cfg_pending, ((k % 2) == 0));
            end
        end
    endtask

`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
    task automatic test_sync();
        do_reset();
        write(0, 3, 2);
        write(1, 5, 3);
        write(2, 2, 1);
        en = 3'b111;
        cycle();
        write(1, 1, 1);
        cycle(); cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        tests++;
        if (tick !== 3'b111 || cfg_pending !== 3'b000 || clk_out !== 3'b111) begin
            fails++;
            $display("FAIL sync: tick=%b pend=%b clk_out=%b, required 111 000 111", tick, cfg_pending, clk_out);
        end
        for (int k = 0; k < 8; k++) begin
            cycle();
            tests++;
            if (clk_out !== m_clk || tick !== m_tick || cfg_pending !== m_pend) begin
                fails++;
                $display("FAIL sync_after k=%0d: clk_out=%b tick=%b pend=%b, required %b %b %b",
                         k, clk_out, tick, cfg_pending, m_clk, m_tick, m_pend);
            end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ((k % 9) == 0) en = 3'($urandom);
            cfg_we     = ($urandom_range(0, 3) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_period = 8'($urandom_range(0, 6));
            cfg_high   = 8'($urandom_range(0, 8));
            rst        = ($urandom_range(0, 99) == 0);
`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
            sync       = ($urandom_range(0, 29) == 0);
`endif
            cycle();
            tests++;
            if (clk_out !== m_clk || tick !== m_tick || cfg_pending !== m_pend) begin
                fails++;
                $display("FAIL random k=%0d: clk_out=%b tick=%b pend=%b, required %b %b %b",
                         k, clk_out, tick, cfg_pending, m_clk, m_tick, m_pend);
            end
        end
        cfg_we = 1'b0; rst = 1'b0; sync = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pending();
        test_extremes();
        test_ignore_and_wrap_write();
        test_reset_mid();
`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
        test_sync();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter N, default 8: width of per-channel period/high/counter fields.
REQ-003 SHALL have parameter DEF_PERIOD, default 1: reset value of every channel's active period.
REQ-004 SHALL have parameter DEF_HIGH, default 1: reset value of every channel's active high-count.
REQ-005 SHALL have port clk  input  1  clock; all logic on posedge clk.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port en  input  NUM_CH  per-channel run enable.
REQ-008 SHALL have port cfg_we  input  1  one-cycle config write strobe.
REQ-009 SHALL have port cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel index.
REQ-010 SHALL have port cfg_period  input  N  period minus one (P = cfg_period+1 cycles).
REQ-011 SHALL have port cfg_high  input  N  cycles high per period.
REQ-012 SHALL have port clk_out  output  NUM_CH  registered divided clocks.
REQ-013 SHALL have port tick  output  NUM_CH  registered one-cycle pulse at period start.
REQ-014 SHALL have port cfg_pending  output  NUM_CH  shadow config waiting for a period boundary.

Function
REQ-015 Per channel, state SHALL be: cnt[N], per_act[N], high_act[N], per_pend[N], high_pend[N], pend_valid.
REQ-016 Enabled channel: if cnt==per_act then cnt_next=0, else cnt_next=cnt+1; counter never exceeds per_act.
REQ-017 clk_out SHALL be registered as en & (cnt_next < high_act_next), unsigned compare; glitch-free by construction.
REQ-018 tick SHALL be registered as en & (cnt_next == 0).
REQ-019 high_act=0 SHALL give clk_out constantly low; high_act>per_act SHALL give clk_out constantly high while enabled.
REQ-020 per_act=0 SHALL give tick every cycle while enabled.
REQ-021 Disabled channel (en=0): cnt_next=0, clk_out=0, tick=0; on the first enabled cycle cnt_next=0, so the first output cycle is period start with tick=1.
REQ-022 cfg_we to an enabled channel SHALL load per_pend/high_pend and set pend_valid; pending values copy to active at the next wrap (cnt==per_act), clearing pend_valid.
REQ-023 cfg_we to a disabled channel SHALL load active registers directly; pend_valid unchanged-cleared.
REQ-024 cfg_we coinciding with a wrap SHALL go to pending and apply at the following wrap (no bypass).
REQ-025 A second cfg_we to a channel with pend_valid=1 SHALL overwrite pending values.
REQ-026 cfg_we with cfg_ch >= NUM_CH SHALL be ignored.
REQ-027 Channels SHALL be fully independent; a write to one channel never disturbs another.
REQ-028 Setting period=2*d+1, high=d+1 SHALL reproduce a 50% divide-by-2*(d+1) clock.

Reset
REQ-029 On rst: cnt=0, per_act=DEF_PERIOD, high_act=DEF_HIGH, pend_valid=0, clk_out=0, tick=0, cfg_pending=0.
REQ-030 rst SHALL take priority over cfg_we, en and sync; reset mid-period discards pending config.

Configuration
REQ-031 With macro CLOCK_DIVIDER_BANK_SYNC_EN defined, SHALL add input sync (1 bit): when high, every enabled channel forces cnt_next=0, applies pending config immediately and asserts tick next cycle; priority rst > sync > normal counting.
REQ-032 Without CLOCK_DIVIDER_BANK_SYNC_EN, port sync SHALL not exist and channels phase-align only via en.

Structure
REQ-033 Package clock_divider_pkg SHALL hold the per-channel config struct (period, high) and default constants.
REQ-034 Per-channel logic SHALL be sub-module clock_divider_chan, instantiated NUM_CH times via generate.

Verification
REQ-035 en[0] rises, period=3, high=2 -> clk_out[0] 1,1,0,0 repeating; tick[0] 1,0,0,0 repeating.
REQ-036 Enabled ch1 period=3 high=2, write period=5 high=1 mid-period -> cfg_pending[1]=1 until wrap, then clk_out[1] 1,0,0,0,0,0 with no short pulse.
REQ-037 high=0 -> clk_out constantly 0; high=9, period=4 -> constantly 1; period=0 -> tick every cycle.
REQ-038 Write with cfg_ch=NUM_CH -> no channel state changes; simultaneous write and wrap -> new value applies one period later.
REQ-039 rst asserted mid-period with pending config -> next cycle all outputs 0, active = DEF_PERIOD/DEF_HIGH, cfg_pending=0.
REQ-040 With CLOCK_DIVIDER_BANK_SYNC_EN, channels at differing phases, pulse sync -> all enabled ticks assert on the same cycle.
